// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_parser
// Desc     : Assembles SYNC/CMD/LEN/ARG/CHK frames from UART bytes into one
//            decoded command with valid/ready; optional CMD_TIMEOUT_EN macro
//            adds an inter-byte timeout.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_parser #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 4,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic        baud_clock,
    input  logic        reset,
    input  logic [7:0]  data_received,
    input  logic        data_rdy,
    input  logic        cmd_ready,
    output logic        cmd_valid,
    output logic [7:0]  cmd_opcode,
    output logic [31:0] cmd_arg,
    output logic [2:0]  cmd_len,
    output logic        err_pulse,
    output logic [2:0]  err_code
);

    localparam logic [7:0] c_max_len     = 8'(MAX_LEN);
    localparam logic [2:0] c_err_len     = 3'd1;
    localparam logic [2:0] c_err_chk     = 3'd2;
    localparam logic [2:0] c_err_overrun = 3'd3;
    localparam logic [2:0] c_err_timeout = 3'd4;

    if (MAX_LEN < 1 || MAX_LEN > 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("uart_cmd_parser: MAX_LEN must be 1..4 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [2:0] {
        WAIT_SYNC = 3'd0,
        GET_CMD   = 3'd1,
        GET_LEN   = 3'd2,
        GET_ARG   = 3'd3,
        GET_CHK   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [2:0]  len_q, len_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] arg_q, arg_d;
    logic [7:0]  chk_q, chk_d;

    logic        cmd_valid_q, cmd_valid_d;
    logic [7:0]  cmd_opcode_q, cmd_opcode_d;
    logic [31:0] cmd_arg_q, cmd_arg_d;
    logic [2:0]  cmd_len_q, cmd_len_d;
    logic        err_pulse_q, err_pulse_d;
    logic [2:0]  err_code_q, err_code_d;

    logic        frame_done;
    logic        timeout_hit;

`ifdef CMD_TIMEOUT_EN
    localparam int                 c_tmo_w   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_max = c_tmo_w'(TIMEOUT_CYCLES);

    logic [c_tmo_w-1:0] tmo_cnt_q, tmo_cnt_d;

    // Counter saturates at the limit; it only matters while a frame is open.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == WAIT_SYNC || data_rdy) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != c_tmo_max) begin
            tmo_cnt_d = tmo_cnt_q + c_tmo_w'(1);
        end
    end

    always_ff @(posedge baud_clock or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign timeout_hit = (state_q != WAIT_SYNC) && (tmo_cnt_q == c_tmo_max);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        len_d        = len_q;
        idx_d        = idx_q;
        arg_d        = arg_q;
        chk_d        = chk_q;
        cmd_valid_d  = cmd_valid_q;
        cmd_opcode_d = cmd_opcode_q;
        cmd_arg_d    = cmd_arg_q;
        cmd_len_d    = cmd_len_q;
        err_pulse_d  = 1'b0;
        err_code_d   = err_code_q;
        frame_done   = 1'b0;

        // A timeout takes priority over a byte arriving in the same cycle.
        if (timeout_hit) begin
            state_d     = WAIT_SYNC;
            err_pulse_d = 1'b1;
            err_code_d  = c_err_timeout;
        end else if (data_rdy) begin
            case (state_q)
                WAIT_SYNC: begin
                    if (data_received == SYNC_BYTE) begin
                        state_d = GET_CMD;
                    end
                end
                GET_CMD: begin
                    opcode_d = data_received;
                    chk_d    = data_received;
                    state_d  = GET_LEN;
                end
                GET_LEN: begin
                    if (data_received > c_max_len) begin
                        err_pulse_d = 1'b1;
                        err_code_d  = c_err_len;
                        state_d     = WAIT_SYNC;
                    end else begin
                        len_d   = data_received[2:0];
                        chk_d   = chk_q ^ data_received;
                        arg_d   = '0;
                        idx_d   = '0;
                        state_d = (data_received == 8'd0) ? GET_CHK : GET_ARG;
                    end
                end
                GET_ARG: begin
                    arg_d[{idx_q, 3'b000} +: 8] = data_received;
                    chk_d = chk_q ^ data_received;
                    idx_d = idx_q + 2'd1;
                    if ({1'b0, idx_q} == (len_q - 3'd1)) begin
                        state_d = GET_CHK;
                    end
                end
                GET_CHK: begin
                    if (data_received != chk_q) begin
                        err_pulse_d = 1'b1;
                        err_code_d  = c_err_chk;
                    end else begin
                        frame_done = 1'b1;
                    end
                    state_d = WAIT_SYNC;
                end
                default: state_d = WAIT_SYNC;
            endcase
        end

        // A completed frame may replace a command accepted in the same cycle.
        if (frame_done) begin
            if (!cmd_valid_q || cmd_ready) begin
                cmd_valid_d  = 1'b1;
                cmd_opcode_d = opcode_q;
                cmd_arg_d    = arg_q;
                cmd_len_d    = len_q;
            end else begin
                err_pulse_d = 1'b1;
                err_code_d  = c_err_overrun;
            end
        end else if (cmd_valid_q && cmd_ready) begin
            cmd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge baud_clock or posedge reset) begin
        if (reset) begin
            state_q      <= WAIT_SYNC;
            opcode_q     <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            arg_q        <= '0;
            chk_q        <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_opcode_q <= '0;
            cmd_arg_q    <= '0;
            cmd_len_q    <= '0;
            err_pulse_q  <= 1'b0;
            err_code_q   <= '0;
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            arg_q        <= arg_d;
            chk_q        <= chk_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_opcode_q <= cmd_opcode_d;
            cmd_arg_q    <= cmd_arg_d;
            cmd_len_q    <= cmd_len_d;
            err_pulse_q  <= err_pulse_d;
            err_code_q   <= err_code_d;
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign cmd_opcode = cmd_opcode_q;
    assign cmd_arg    = cmd_arg_q;
    assign cmd_len    = cmd_len_q;
    assign err_pulse  = err_pulse_q;
    assign err_code   = err_code_q;

endmodule

`default_nettype wire
